// File: rtl/add_sub_fp_if.sv
// Start/done bus of the floating-point adder/subtractor.
// master drives the request side; slave is the arithmetic unit.
interface add_sub_fp_if #(
  parameter int Size = 64
);
  logic            start;
  logic            sub;
  logic [2:0]      rounding_mode;
  logic [Size-1:0] operand_a;
  logic [Size-1:0] operand_b;
  logic [Size-1:0] result;
  logic            overflow;
  logic            underflow;
  logic            inexact;
  logic            invalid;
  logic            done;
  logic [2:0]      fsm_state;

  modport master (
    output start, sub, rounding_mode, operand_a, operand_b,
    input  result, overflow, underflow, inexact, invalid, done, fsm_state
  );

  modport slave (
    input  start, sub, rounding_mode, operand_a, operand_b,
    output result, overflow, underflow, inexact, invalid, done, fsm_state
  );
endinterface

// File: rtl/add_sub_fp.sv
// Multi-cycle IEEE-754 add/subtract with all five RISC-V rounding modes.
// One pipeline stage per FSM state: align, add, normalize, round.
module add_sub_fp #(
  parameter int Size = 64
) (
  input logic         clk,
  input logic         reset,
  add_sub_fp_if.slave bus
);
  localparam int EW = (Size == 32) ? 8 : (Size == 64) ? 11 : 15;
  localparam int FW = Size - EW - 1;
  localparam int SW = FW + 1;
  localparam int MW = SW + 3;
  localparam logic [EW-1:0] EXP_ONES = '1;
  localparam logic [EW-1:0] EXP_MAX  = {{(EW-1){1'b1}}, 1'b0};
  localparam logic [EW-1:0] EXP_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW:0]   E1       = {{EW{1'b0}}, 1'b1};
  localparam logic [Size-1:0] QNAN   = {1'b0, EXP_ONES, 1'b1, {(FW-1){1'b0}}};
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  // Handshake: start is sampled only in S_IDLE; the operands are latched on
  // that edge, and done is a single-cycle pulse with result/flags stable
  // from that cycle until the next done or reset.
  state_t state, state_n;

  logic [Size-1:0] a_q, b_q;
  logic            sub_q;
  logic [2:0]      rm_q;
  logic            sign_q, eff_sub_q, special_q, spec_invalid_q, zero_q;
  logic [Size-1:0] special_val_q;
  logic [MW-1:0]   big_q, small_q, norm_q;
  logic [EW:0]     exp_q, nexp_q;
  logic [MW:0]     sum_q;
  logic [Size-1:0] result_q;
  logic            overflow_q, underflow_q, inexact_q, invalid_q;

  function automatic logic [EW:0] lzc(input logic [MW-1:0] v);
    logic [EW:0] n;
    logic        found;
    n = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found && !v[i]) n = n + E1;
      else found = 1'b1;
    end
    return n;
  endfunction

  // Unpack, classify specials and align the smaller operand
  logic            sa, sb, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_big;
  logic [EW-1:0]   ea, eb, expa, expb, diff, big_exp;
  logic [FW-1:0]   fa, fb;
  logic [SW-1:0]   sig_a, sig_b, sig_small;
  logic [MW-1:0]   big_ext, small_ext, aligned;
  logic            big_sign, special, spec_invalid;
  logic [Size-1:0] special_val;

  always_comb begin
    sa     = a_q[Size-1];
    sb     = b_q[Size-1] ^ sub_q;
    ea     = a_q[Size-2:FW];
    eb     = b_q[Size-2:FW];
    fa     = a_q[FW-1:0];
    fb     = b_q[FW-1:0];
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    a_snan = a_nan && !fa[FW-1];
    b_snan = b_nan && !fb[FW-1];
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    sig_a  = {(ea != '0), fa};
    sig_b  = {(eb != '0), fb};
    expa   = (ea == '0) ? EXP_ONE : ea;
    expb   = (eb == '0) ? EXP_ONE : eb;
    a_big  = (expa > expb) || ((expa == expb) && (sig_a >= sig_b));
    if (a_big) begin
      big_exp = expa; big_sign = sa; big_ext = {sig_a, 3'b000};
      sig_small = sig_b; diff = expa - expb;
    end else begin
      big_exp = expb; big_sign = sb; big_ext = {sig_b, 3'b000};
      sig_small = sig_a; diff = expb - expa;
    end
    small_ext = {sig_small, 3'b000};
    aligned   = (small_ext >> diff)
              | {{(MW-1){1'b0}}, |(small_ext & ~({MW{1'b1}} << diff))};
    special      = 1'b1;
    spec_invalid = 1'b0;
    special_val  = QNAN;
    if (a_nan || b_nan)                  spec_invalid = a_snan || b_snan;
    else if (a_inf && b_inf && (sa != sb)) spec_invalid = 1'b1;
    else if (a_inf)                      special_val = {sa, EXP_ONES, {FW{1'b0}}};
    else if (b_inf)                      special_val = {sb, EXP_ONES, {FW{1'b0}}};
    else                                 special = 1'b0;
  end

  // Normalize: carry shifts right, otherwise left-shift bounded by exponent 1
  logic [EW:0]   lz, max_sh, shamt, n_exp;
  logic [MW-1:0] n_mant;

  always_comb begin
    lz     = lzc(sum_q[MW-1:0]);
    max_sh = exp_q - E1;
    shamt  = (lz < max_sh) ? lz : max_sh;
    if (sum_q[MW]) begin
      n_mant = sum_q[MW:1] | {{(MW-1){1'b0}}, sum_q[0]};
      n_exp  = exp_q + E1;
    end else begin
      n_mant = sum_q[MW-1:0] << shamt;
      n_exp  = exp_q - shamt;
    end
    if (!n_mant[MW-1]) n_exp = '0;
  end

  // Round and resolve overflow, zero sign and flags
  logic [SW-1:0]   mant;
  logic [SW:0]     rounded;
  logic [EW:0]     r_exp;
  logic            g, r, s, grs, up, ovf, tiny, res_sign, to_inf;
  logic [Size-1:0] r_val;

  always_comb begin
    mant = norm_q[MW-1:3];
    g    = norm_q[2];
    r    = norm_q[1];
    s    = norm_q[0];
    grs  = g | r | s;
    res_sign = (zero_q && eff_sub_q) ? (rm_q == RM_RDN) : sign_q;
    case (rm_q)
      RM_RTZ:  begin up = 1'b0;              to_inf = 1'b0;      end
      RM_RDN:  begin up = res_sign & grs;    to_inf = res_sign;  end
      RM_RUP:  begin up = !res_sign & grs;   to_inf = !res_sign; end
      RM_RMM:  begin up = g;                 to_inf = 1'b1;      end
      default: begin up = g & (r | s | mant[0]); to_inf = 1'b1;  end
    endcase
    rounded = {1'b0, mant} + {{SW{1'b0}}, up};
    r_exp   = nexp_q;
    if (rounded[SW])                          r_exp = nexp_q + E1;
    else if ((nexp_q == '0) && rounded[SW-1]) r_exp = E1;
    ovf  = r_exp >= {1'b0, EXP_ONES};
    tiny = (r_exp == '0);
    if (ovf && to_inf) r_val = {res_sign, EXP_ONES, {FW{1'b0}}};
    else if (ovf)      r_val = {res_sign, EXP_MAX, {FW{1'b1}}};
    else               r_val = {res_sign, r_exp[EW-1:0], rounded[FW-1:0]};
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (bus.start) state_n = S_ALIGN;
      S_ALIGN: state_n = S_ADD;
      S_ADD:   state_n = S_NORM;
      S_NORM:  state_n = S_ROUND;
      S_ROUND: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0; b_q <= '0; sub_q <= 1'b0; rm_q <= '0;
      sign_q <= 1'b0; eff_sub_q <= 1'b0; special_q <= 1'b0;
      spec_invalid_q <= 1'b0; special_val_q <= '0; zero_q <= 1'b0;
      big_q <= '0; small_q <= '0; exp_q <= '0; sum_q <= '0;
      norm_q <= '0; nexp_q <= '0;
      result_q <= '0; overflow_q <= 1'b0; underflow_q <= 1'b0;
      inexact_q <= 1'b0; invalid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          a_q   <= bus.operand_a;
          b_q   <= bus.operand_b;
          sub_q <= bus.sub;
          rm_q  <= bus.rounding_mode;
        end
        S_ALIGN: begin
          big_q          <= big_ext;
          small_q        <= aligned;
          exp_q          <= {1'b0, big_exp};
          sign_q         <= big_sign;
          eff_sub_q      <= sa ^ sb;
          special_q      <= special;
          spec_invalid_q <= spec_invalid;
          special_val_q  <= special_val;
        end
        S_ADD: sum_q <= eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                  : ({1'b0, big_q} + {1'b0, small_q});
        S_NORM: begin
          norm_q <= n_mant;
          nexp_q <= n_exp;
          zero_q <= (sum_q == '0);
        end
        S_ROUND: begin
          if (special_q) begin
            result_q    <= special_val_q;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
            invalid_q   <= spec_invalid_q;
          end else begin
            result_q    <= r_val;
            overflow_q  <= ovf;
            underflow_q <= tiny & (grs | ovf);
            inexact_q   <= grs | ovf;
            invalid_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.inexact   = inexact_q;
  assign bus.invalid   = invalid_q;
  assign bus.done      = (state == S_DONE);
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_add_sub_fp.sv
// Directed-vector bench for add_sub_fp at single and double precision.
module tb_add_sub_fp;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  add_sub_fp_if #(.Size(64)) bus64 ();
  add_sub_fp_if #(.Size(32)) bus32 ();

  add_sub_fp #(.Size(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));
  add_sub_fp #(.Size(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // flags are packed {overflow, underflow, inexact, invalid}
  task automatic run_op(input string tag, input bit is32, input logic [63:0] a,
                        input logic [63:0] b, input logic sub_i, input logic [2:0] rm,
                        input logic [63:0] exp_res, input logic [3:0] exp_flags);
    int          cycles;
    bit          got;
    logic [63:0] res, expv;
    logic [3:0]  flags;
    @(negedge clk);
    if (is32) begin
      bus32.operand_a = a[31:0]; bus32.operand_b = b[31:0];
      bus32.sub = sub_i; bus32.rounding_mode = rm; bus32.start = 1'b1;
    end else begin
      bus64.operand_a = a; bus64.operand_b = b;
      bus64.sub = sub_i; bus64.rounding_mode = rm; bus64.start = 1'b1;
    end
    exp_q.push_back(exp_res);
    @(posedge clk);
    #1;
    if (is32) begin
      bus32.start = 1'b0; bus32.operand_a = $urandom; bus32.operand_b = $urandom;
      bus32.sub = 1'($urandom_range(0, 1)); bus32.rounding_mode = 3'($urandom_range(0, 7));
    end else begin
      bus64.start = 1'b0; bus64.operand_a = {$urandom, $urandom};
      bus64.operand_b = {$urandom, $urandom};
      bus64.sub = 1'($urandom_range(0, 1)); bus64.rounding_mode = 3'($urandom_range(0, 7));
    end
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 20) begin
      @(negedge clk);
      cycles++;
      got = is32 ? bus32.done : bus64.done;
    end
    expv = exp_q.pop_front();
    check({tag, " done"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, " latency"}, 64'(cycles), 64'd5);
      res   = is32 ? {32'd0, bus32.result} : bus64.result;
      flags = is32 ? {bus32.overflow, bus32.underflow, bus32.inexact, bus32.invalid}
                   : {bus64.overflow, bus64.underflow, bus64.inexact, bus64.invalid};
      check({tag, " result"}, res, expv);
      check({tag, " flags"}, 64'(flags), 64'(exp_flags));
      @(negedge clk);
      check({tag, " pulse"}, 64'(is32 ? bus32.done : bus64.done), 64'd0);
    end
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    bus64.start = 1'b0; bus64.sub = 1'b0; bus64.rounding_mode = '0;
    bus64.operand_a = '0; bus64.operand_b = '0;
    bus32.start = 1'b0; bus32.sub = 1'b0; bus32.rounding_mode = '0;
    bus32.operand_a = '0; bus32.operand_b = '0;
    repeat (3) @(negedge clk);
    check("rst result64", bus64.result, 64'd0);
    check("rst flags64", 64'({bus64.overflow, bus64.underflow, bus64.inexact, bus64.invalid}), 64'd0);
    check("rst done64", 64'(bus64.done), 64'd0);
    check("rst result32", {32'd0, bus32.result}, 64'd0);
    reset = 1'b0;

    run_op("d cancel",    0, 64'h3FF8000000000000, 64'hBFF8000000000000, 0, 3'd0, 64'h0000000000000000, 4'b0000);
    run_op("d sub3",      0, 64'h3FF8000000000000, 64'hBFF8000000000000, 1, 3'd0, 64'h4008000000000000, 4'b0000);
    run_op("d zero",      0, 64'h0000000000000000, 64'h0000000000000000, 0, 3'd0, 64'h0000000000000000, 4'b0000);
    run_op("d tinysub",   0, 64'h000FF00000000001, 64'h3FE0000000000000, 1, 3'd0, 64'hBFE0000000000000, 4'b0010);
    run_op("d ovf rne",   0, 64'h7FEFF00000000001, 64'h7FE0000000000000, 0, 3'd0, 64'h7FF0000000000000, 4'b1010);
    run_op("d ovf rtz",   0, 64'h7FEFF00000000001, 64'h7FE0000000000000, 0, 3'd1, 64'h7FEFFFFFFFFFFFFF, 4'b1010);
    run_op("d ovf rm7",   0, 64'h7FEFF00000000001, 64'h7FE0000000000000, 0, 3'd7, 64'h7FF0000000000000, 4'b1010);
    run_op("d sub+norm",  0, 64'h000FF00000000001, 64'h0010100000000000, 0, 3'd0, 64'h0020000000000000, 4'b0010);
    run_op("d subnorm",   0, 64'h000FF00000000001, 64'h0010100000000000, 1, 3'd0, 64'h80001FFFFFFFFFFF, 4'b0000);
    run_op("d carry",     0, 64'h42A3FE0580082268, 64'hC2A0000000000000, 1, 3'd0, 64'h42B1FF02C0041134, 4'b0000);
    run_op("d rdn zero",  0, 64'h3FF8000000000000, 64'h3FF8000000000000, 1, 3'd2, 64'h8000000000000000, 4'b0000);

    run_op("s add",       1, 64'h3E800000, 64'h42C80000, 0, 3'd0, 64'h42C88000, 4'b0000);
    run_op("s sub",       1, 64'h40C88000, 64'h40700000, 1, 3'd0, 64'h40210000, 4'b0000);
    run_op("s rdn",       1, 64'hC060001F, 64'hC1700009, 0, 3'd2, 64'hC1940009, 4'b0010);
    run_op("s qnan",      1, 64'h7FC00000, 64'h3F800000, 0, 3'd0, 64'h7FC00000, 4'b0000);
    run_op("s inf-inf",   1, 64'h7F800000, 64'hFF800000, 0, 3'd0, 64'h7FC00000, 4'b0001);
    run_op("s snan",      1, 64'h7F800001, 64'h3F800000, 0, 3'd0, 64'h7FC00000, 4'b0001);
    run_op("s inf+1",     1, 64'h7F800000, 64'h3F800000, 0, 3'd0, 64'h7F800000, 4'b0000);
    run_op("s rup negov", 1, 64'hFF7FFFFF, 64'hFF7FFFFF, 0, 3'd3, 64'hFF7FFFFF, 4'b1010);
    run_op("s rup posov", 1, 64'h7F7FFFFF, 64'h7F7FFFFF, 0, 3'd3, 64'h7F800000, 4'b1010);
    run_op("s rmm tie",   1, 64'h3F800000, 64'h33800000, 0, 3'd4, 64'h3F800001, 4'b0010);
    run_op("s rne tie",   1, 64'h3F800000, 64'h33800000, 0, 3'd0, 64'h3F800000, 4'b0010);

    // abort an operation in flight with reset
    @(negedge clk);
    bus32.operand_a = 32'h3E800000; bus32.operand_b = 32'h42C80000;
    bus32.sub = 1'b0; bus32.rounding_mode = 3'd0; bus32.start = 1'b1;
    @(posedge clk);
    #1 bus32.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort result", {32'd0, bus32.result}, 64'd0);
    check("abort flags", 64'({bus32.overflow, bus32.underflow, bus32.inexact, bus32.invalid}), 64'd0);
    check("abort state", 64'(bus32.fsm_state), 64'd0);
    reset = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus32.done) pulses++;
    end
    check("abort no done", 64'(pulses), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
